// File: rtl/wb_pipe_monitor.sv
// Purpose: passive checker for a pipelined Wishbone B4 bus; tracks outstanding requests and raises sticky rule flags.
// Latency: flags, first_err, outstanding and txn_cnt reflect a bus cycle on the following clk edge.
// Backpressure: none; observes cyc/stb/stall/ack only and drives nothing onto the bus.
//
// Ports:
//   clk, reset_n          bus clock, async active-low reset
//   cyc, stb, we          master control
//   stall, ack            slave handshake
//   adr, dat_m, dat_s     address, write data, read data (only inspected for X/Z)
//   clr                   sync clear of err_flags / first_err / txn_cnt
//   err                   OR of err_flags
//   err_flags[5:0]        {TIMEOUT, OVERFLOW, SPURIOUS, X_RSP, X_REQ, X_CTRL}
//   first_err             index of first flag raised since reset/clr, 7 = none
//   outstanding           accepted-but-unacked request count
//   txn_cnt               non-spurious ACKs seen, saturating
module wb_pipe_monitor #(
  parameter int ADR_W       = 16,
  parameter int DAT_W       = 16,
  parameter int MAX_OUTST   = 4,
  parameter int ACK_TIMEOUT = 16,
  parameter int CNT_W       = 16
) (
  input  logic                               clk,
  input  logic                               reset_n,
  input  logic                               cyc,
  input  logic                               stb,
  input  logic                               we,
  input  logic                               stall,
  input  logic                               ack,
  input  logic [ADR_W-1:0]                   adr,
  input  logic [DAT_W-1:0]                   dat_m,
  input  logic [DAT_W-1:0]                   dat_s,
  input  logic                               clr,
  output logic                               err,
  output logic [5:0]                         err_flags,
  output logic [2:0]                         first_err,
  output logic [$clog2(MAX_OUTST+1)-1:0]     outstanding,
  output logic [CNT_W-1:0]                   txn_cnt
);

  localparam int OW = $clog2(MAX_OUTST + 1);
  localparam int AW = $clog2(ACK_TIMEOUT + 1);
  localparam logic [OW-1:0] MAX_C  = OW'(MAX_OUTST);
  localparam logic [AW-1:0] TMO_C  = AW'(ACK_TIMEOUT);
  localparam logic [AW-1:0] TMO_M1 = AW'(ACK_TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, ACTIVE, WAIT} state_t;

  state_t               state, state_nxt;
  logic [AW-1:0]        age, age_nxt;
  logic [MAX_OUTST-1:0] we_q, we_nxt;   // WE of each outstanding request, bit 0 = oldest
  logic [OW-1:0]        out_nxt, wr_idx;
  logic                 issue, done, zl, spurious, real_done, overflow, push, pop;
  logic                 oldest_we, tmo, cyc_drop, x_rsp;
  logic                 x_ctrl, x_req, x_dat_s;
  logic [5:0]           new_flags, flags_nxt;
  logic [2:0]           first_nxt;
  logic [CNT_W-1:0]     cnt_nxt;

  // X/Z detection only has meaning in a 4-state simulator; hardware sees 0.
`ifdef SYNTHESIS
  assign x_ctrl  = 1'b0;
  assign x_req   = 1'b0;
  assign x_dat_s = 1'b0;
`else
  assign x_ctrl  = $isunknown(cyc) || (cyc && $isunknown({stb, stall, ack}));
  assign x_req   = cyc && stb && ($isunknown(adr) || $isunknown(we) || (we && $isunknown(dat_m)));
  assign x_dat_s = $isunknown(dat_s);
`endif

  always_comb begin
    issue     = cyc & stb & ~stall;
    done      = cyc & ack;
    // An ack in the same cycle as the first issue completes that request with zero latency.
    zl        = issue & done & (outstanding == '0);
    spurious  = done & ~issue & (outstanding == '0);
    real_done = done & ~spurious;
    pop       = done & (outstanding != '0);
    overflow  = issue & ~done & (outstanding == MAX_C);
    push      = issue & ~zl & ~overflow;
    oldest_we = zl ? we : we_q[0];
    x_rsp     = real_done & ~oldest_we & x_dat_s;
    tmo       = (state == WAIT) & cyc & ~done & (age == TMO_M1);
    cyc_drop  = (state == WAIT) & ~cyc;   // abandoned requests count as a timeout

    // WE FIFO: pop shifts toward bit 0, push lands behind the surviving entries.
    we_nxt = pop ? (we_q >> 1) : we_q;
    wr_idx = outstanding - OW'(pop);
    for (int i = 0; i < MAX_OUTST; i++) begin
      if (push && wr_idx == OW'(i)) we_nxt[i] = we;
    end
    if (!cyc) we_nxt = '0;

    out_nxt = cyc ? (outstanding + OW'(push) - OW'(pop)) : '0;

    if (!cyc)                 state_nxt = IDLE;
    else if (out_nxt != '0)   state_nxt = WAIT;
    else                      state_nxt = ACTIVE;

    // age restarts on entry to WAIT and on each ack; holds once the limit is hit
    // so the timeout fires once per stall episode.
    if (!cyc || done || state != WAIT) age_nxt = '0;
    else if (age == TMO_C)             age_nxt = age;
    else                               age_nxt = age + 1'b1;

    new_flags = {tmo | cyc_drop, overflow, spurious, x_rsp, x_req, x_ctrl};
    flags_nxt = (clr ? 6'd0 : err_flags) | new_flags;

    first_nxt = clr ? 3'd7 : first_err;
    if (first_nxt == 3'd7 && new_flags != 6'd0) begin
      for (int i = 5; i >= 0; i--) begin
        if (new_flags[i]) first_nxt = 3'(i);
      end
    end

    cnt_nxt = clr ? '0 : txn_cnt;
    if (real_done && cnt_nxt != '1) cnt_nxt = cnt_nxt + 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      age         <= '0;
      we_q        <= '0;
      outstanding <= '0;
      err_flags   <= '0;
      first_err   <= 3'd7;
      txn_cnt     <= '0;
    end else begin
      state       <= state_nxt;
      age         <= age_nxt;
      we_q        <= we_nxt;
      outstanding <= out_nxt;
      err_flags   <= flags_nxt;
      first_err   <= first_nxt;
      txn_cnt     <= cnt_nxt;
    end
  end

  assign err = |err_flags;

endmodule
